johnson_decoder: RTL and testbench
==================================

# johnson_decoder

Receive-side companion to the 8-bit Johnson counter. Samples the counter's eight one-hot-style outputs q7..q0 and decodes each legal Johnson state to a 4-bit phase index 0..15. Checks that successive samples advance by exactly one phase, and maintains a lock flag and a saturating error count. Sits beside any Johnson-sequenced block as a phase decoder and health monitor.

## Interface
- LOCK_CNT, 4, consecutive correct steps required to assert locked (1..15)
- ERR_W, 8, width of err_cnt
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-low
- en  input  1  sample strobe; the block evaluates q7..q0 only on edges where en=1
- q7..q0  input  1 each  Johnson counter state bits, q7 = MSB
- phase  output  4  decoded phase of last legal sample
- phase_valid  output  1  last accepted sample was legal
- illegal  output  1  one-cycle pulse: accepted sample not a Johnson state
- seq_err  output  1  one-cycle pulse: error detected while locked
- locked  output  1  sequence tracking established
- err_cnt  output  ERR_W  saturating count of seq_err pulses

## Operation
- Legal sequence, generated from 00000000 by q <= {q[6:0], ~q7}: 00000000, 00000001, 00000011, …, 11111111, 11111110, …, 10000000, then back to 00000000.
- Legal state: at most one position i in 1..7 where q[i] != q[i-1]. There are 16 legal codes.
- Decode when q7=0: phase = number of ones (0..7).
- Decode when q7=1: phase = 8 + number of zeros (8..15).
- Internal registers:
  - prev_phase (4 bits)
  - have_prev (1 bit)
  - run_cnt (4 bits)
  - state in {UNLOCKED, LOCKED}
- Definition: step_ok = have_prev & legal & (dec == prev_phase + 1 mod 16). The mod-16 wrap means 15 -> 0 is correct.
- Actions on every accepted sample (en=1):
  - illegal <= !legal.
  - phase_valid <= legal.
  - If legal: phase <= dec and prev_phase <= dec. If illegal, phase holds its previous value.
  - have_prev <= legal.
- UNLOCKED state:
  - If step_ok: run_cnt += 1. When run_cnt reaches LOCK_CNT, go to LOCKED and set locked <= 1.
  - If not step_ok: run_cnt <= 0.
- LOCKED state:
  - If step_ok: no change.
  - If not step_ok: seq_err <= 1, err_cnt += 1 (saturating at 2^ERR_W-1), go to UNLOCKED, locked <= 0, run_cnt <= 0.
  - If the offending sample is legal, it becomes the new reference, so re-lock can start from the next step.
- A repeated phase (a stalled counter sampled with en=1) counts as a mis-step.
- A backward step counts as a mis-step.
- With en=0: no evaluation, all state held, illegal and seq_err driven 0.
- Errors while UNLOCKED do not count and do not pulse seq_err; illegal still pulses.

## Timing
- All outputs are registered. Results for the sample taken at edge k are visible immediately after edge k (latency 1 edge, no combinational input-to-output path).
- illegal and seq_err are high for exactly one cycle per accepted offending sample. They are 0 on every non-accepted cycle.
- Lock timing, counter free-running from reset with en=1:
  - Samples phase 0,1,2,3,4 arrive at edges 0..4.
  - locked rises after edge 4, the LOCK_CNT-th step_ok.
- Drop timing: locked falls on the same edge that seq_err pulses.
- Reset (rst=0), asynchronous, at any time including mid-lock:
  - phase=0, phase_valid=0, illegal=0, seq_err=0, locked=0, err_cnt=0.
  - Internal: have_prev=0, run_cnt=0, state UNLOCKED.
- First edge after rst deasserts: treated as a fresh sample with have_prev=0.
- err_cnt at its maximum plus a further error: seq_err still pulses and err_cnt holds at its maximum.

## Test plan
- Free-run test: reset, then drive the true Johnson sequence from 00000000 with en=1 every cycle.
  - phase must read 0,1,2,…; phase_valid=1 throughout.
  - locked must rise after the phase-4 sample.
  - The 10000000 -> 00000000 transition decodes 15 -> 0 with no seq_err.
- Illegal code while locked: inject 01010101.
  - Response: illegal=1, seq_err=1, locked falls, err_cnt=1, phase holds its prior value, phase_valid=0.
  - Resuming legal codes re-locks after 4 further correct steps.
- Skip while locked: drive 00000011 then 00001111 (phase 2 -> 4).
  - Response: seq_err pulse, err_cnt increments, phase=4, locked=0.
  - Then 00011111 (phase 5) gives run_cnt=1.
- Stall: hold en=0 for 10 cycles mid-sequence while q changes arbitrarily.
  - Response: no pulses, outputs frozen, locked retained.
  - en=1 with the next expected code continues without error.
  - en=1 with a repeated code gives a seq_err.
- Saturation: with ERR_W=4, force 20 lock/error cycles.
  - Response: err_cnt stops at 15 while seq_err keeps pulsing.
- Reset: assert rst asynchronously mid-lock, away from any clock edge.
  - Response: all outputs go to their reset values immediately.
  - After release, lock needs a full LOCK_CNT steps again.

Source files
------------

// File: rtl/johnson_decoder.sv
// -----------------------------------------------------------------------------
// johnson_decoder
//
// Receive-side phase decoder and health monitor for an 8-bit Johnson counter.
// On every edge where en=1 the eight counter bits are sampled and checked:
//   - legality: at most one 0/1 boundary between adjacent bits (16 codes),
//   - decode:   q7=0 -> phase = ones (0..7); q7=1 -> phase = 8 + zeros (8..15),
//   - sequence: each legal sample must be exactly one phase (mod 16) ahead of
//               the previous legal sample.
// LOCK_CNT consecutive correct steps establish lock. Any mis-step while locked
// pulses seq_err, bumps a saturating error counter and drops lock.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous reset, active-low
//   en           in   sample strobe
//   q7..q0       in   Johnson counter bits, q7 = MSB
//   phase        out  [3:0] decoded phase of the last legal sample
//   phase_valid  out  last accepted sample was legal
//   illegal      out  one-cycle pulse: accepted sample was not a Johnson code
//   seq_err      out  one-cycle pulse: mis-step detected while locked
//   locked       out  sequence tracking established
//   err_cnt      out  [ERR_W-1:0] saturating count of seq_err pulses
// -----------------------------------------------------------------------------
module johnson_decoder #(
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             q7,
  input  logic             q6,
  input  logic             q5,
  input  logic             q4,
  input  logic             q3,
  input  logic             q2,
  input  logic             q1,
  input  logic             q0,
  output logic [3:0]       phase,
  output logic             phase_valid,
  output logic             illegal,
  output logic             seq_err,
  output logic             locked,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [3:0]       LOCK_N  = 4'(LOCK_CNT);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  function automatic logic [3:0] popcnt8(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

  logic [7:0]       q_vec;
  logic [3:0]       ones;
  logic [3:0]       edges;
  logic             legal;
  logic [3:0]       dec;
  logic             step_ok;

  state_t           state_q, state_d;
  logic [3:0]       phase_q, phase_d;
  logic [3:0]       prev_phase_q, prev_phase_d;
  logic             have_prev_q, have_prev_d;
  logic [3:0]       run_cnt_q, run_cnt_d;
  logic             phase_valid_q, phase_valid_d;
  logic             illegal_q, illegal_d;
  logic             seq_err_q, seq_err_d;
  logic             locked_q, locked_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    q_vec = {q7, q6, q5, q4, q3, q2, q1, q0};
    ones  = popcnt8(q_vec);
    // Adjacent-bit differences; a Johnson code has at most one boundary.
    edges = popcnt8({1'b0, q_vec[7:1] ^ q_vec[6:0]});
    legal = (edges <= 4'd1);
    // q7=1: 8 + (8 - ones), computed mod 16 (ones=1 gives 15, ones=8 gives 8).
    dec   = q7 ? (4'd8 + (4'd8 - ones)) : ones;
    step_ok = have_prev_q & legal & (dec == prev_phase_q + 4'd1);
  end

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    prev_phase_d  = prev_phase_q;
    have_prev_d   = have_prev_q;
    run_cnt_d     = run_cnt_q;
    phase_valid_d = phase_valid_q;
    locked_d      = locked_q;
    err_cnt_d     = err_cnt_q;
    illegal_d     = 1'b0;
    seq_err_d     = 1'b0;

    if (en) begin
      illegal_d     = !legal;
      phase_valid_d = legal;
      have_prev_d   = legal;
      if (legal) begin
        phase_d      = dec;
        prev_phase_d = dec;
      end

      case (state_q)
        UNLOCKED: begin
          if (step_ok) begin
            if (run_cnt_q + 4'd1 == LOCK_N) begin
              state_d   = LOCKED;
              locked_d  = 1'b1;
              run_cnt_d = 4'd0;
            end else begin
              run_cnt_d = run_cnt_q + 4'd1;
            end
          end else begin
            run_cnt_d = 4'd0;
          end
        end
        LOCKED: begin
          // A legal offender has already been loaded as the new reference
          // above, so re-lock counting starts with the following sample.
          if (!step_ok) begin
            seq_err_d = 1'b1;
            err_cnt_d = (err_cnt_q == ERR_MAX) ? err_cnt_q : err_cnt_q + 1'b1;
            state_d   = UNLOCKED;
            locked_d  = 1'b0;
            run_cnt_d = 4'd0;
          end
        end
        default: begin
          state_d  = UNLOCKED;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= UNLOCKED;
      phase_q       <= 4'd0;
      prev_phase_q  <= 4'd0;
      have_prev_q   <= 1'b0;
      run_cnt_q     <= 4'd0;
      phase_valid_q <= 1'b0;
      illegal_q     <= 1'b0;
      seq_err_q     <= 1'b0;
      locked_q      <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      prev_phase_q  <= prev_phase_d;
      have_prev_q   <= have_prev_d;
      run_cnt_q     <= run_cnt_d;
      phase_valid_q <= phase_valid_d;
      illegal_q     <= illegal_d;
      seq_err_q     <= seq_err_d;
      locked_q      <= locked_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign phase       = phase_q;
  assign phase_valid = phase_valid_q;
  assign illegal     = illegal_q;
  assign seq_err     = seq_err_q;
  assign locked      = locked_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// -----------------------------------------------------------------------------
// tb_johnson_decoder
//
// Directed bench for johnson_decoder (LOCK_CNT=4, ERR_W=4). Walks through
// reset, free-run lock and wrap, illegal injection, phase skip, en stall,
// error-counter saturation and asynchronous mid-lock reset.
// -----------------------------------------------------------------------------
module tb_johnson_decoder;

  logic       clk;
  logic       rst;
  logic       en;
  logic       q7, q6, q5, q4, q3, q2, q1, q0;
  logic [3:0] phase;
  logic       phase_valid;
  logic       illegal;
  logic       seq_err;
  logic       locked;
  logic [3:0] err_cnt;

  int errors = 0;
  int checks = 0;

  // Legal Johnson codes indexed by phase.
  logic [7:0] jc [16] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
                          8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};

  johnson_decoder #(.LOCK_CNT(4), .ERR_W(4)) dut (
    .clk(clk), .rst(rst), .en(en),
    .q7(q7), .q6(q6), .q5(q5), .q4(q4), .q3(q3), .q2(q2), .q1(q1), .q0(q0),
    .phase(phase), .phase_valid(phase_valid), .illegal(illegal),
    .seq_err(seq_err), .locked(locked), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] ph, input logic pv,
                            input logic ill, input logic se, input logic lk,
                            input logic [3:0] ec);
    chk({tag, ".phase"},       32'(phase),       32'(ph));
    chk({tag, ".phase_valid"}, 32'(phase_valid), 32'(pv));
    chk({tag, ".illegal"},     32'(illegal),     32'(ill));
    chk({tag, ".seq_err"},     32'(seq_err),     32'(se));
    chk({tag, ".locked"},      32'(locked),      32'(lk));
    chk({tag, ".err_cnt"},     32'(err_cnt),     32'(ec));
  endtask

  // Apply one sample, let one rising edge pass, then settle off the edge.
  task automatic drive(input logic [7:0] code, input logic e);
    {q7, q6, q5, q4, q3, q2, q1, q0} = code;
    en = e;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  initial begin
    logic [3:0] exp_err;
    logic [3:0] cur;

    rst = 1'b0;
    en  = 1'b0;
    {q7, q6, q5, q4, q3, q2, q1, q0} = 8'h00;
    exp_err = 4'd0;

    // Reset values
    #2;
    expect_out("reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Free run: lock after phase 4, wrap 15 -> 0 without error
    for (int i = 0; i < 20; i++) begin
      drive(jc[i % 16], 1'b1);
      expect_out($sformatf("free%0d", i), 4'(i % 16), 1'b1, 1'b0, 1'b0, (i >= 4), exp_err);
    end

    // Illegal code while locked (last phase 3)
    drive(8'h55, 1'b1);
    exp_err = sat_inc(exp_err);
    expect_out("illegal", 4'd3, 1'b0, 1'b1, 1'b1, 1'b0, exp_err);
    // First legal sample is only a reference; 4 more steps re-lock
    for (int p = 4; p <= 8; p++) begin
      drive(jc[p], 1'b1);
      expect_out($sformatf("relock%0d", p), 4'(p), 1'b1, 1'b0, 1'b0, (p == 8), exp_err);
    end

    // Continue locked up to phase 2, then skip to phase 4
    for (int p = 9; p <= 18; p++) begin
      drive(jc[p % 16], 1'b1);
      expect_out($sformatf("run%0d", p), 4'(p % 16), 1'b1, 1'b0, 1'b0, 1'b1, exp_err);
    end
    drive(8'h0F, 1'b1);
    exp_err = sat_inc(exp_err);
    expect_out("skip", 4'd4, 1'b1, 1'b0, 1'b1, 1'b0, exp_err);
    for (int p = 5; p <= 8; p++) begin
      drive(jc[p], 1'b1);
      expect_out($sformatf("skiprelock%0d", p), 4'(p), 1'b1, 1'b0, 1'b0, (p == 8), exp_err);
    end

    // Stall with en=0 while q wanders arbitrarily
    for (int i = 0; i < 10; i++) begin
      drive(8'($urandom), 1'b0);
      expect_out($sformatf("stall%0d", i), 4'd8, 1'b1, 1'b0, 1'b0, 1'b1, exp_err);
    end
    drive(jc[9], 1'b1);
    expect_out("stall_resume", 4'd9, 1'b1, 1'b0, 1'b0, 1'b1, exp_err);
    for (int i = 0; i < 3; i++) drive(8'($urandom), 1'b0);
    expect_out("stall2", 4'd9, 1'b1, 1'b0, 1'b0, 1'b1, exp_err);
    drive(jc[9], 1'b1);
    exp_err = sat_inc(exp_err);
    expect_out("repeat", 4'd9, 1'b1, 1'b0, 1'b1, 1'b0, exp_err);

    // Saturation: 20 lock / repeat-error cycles
    cur = 4'd9;
    for (int k = 0; k < 20; k++) begin
      for (int s = 0; s < 4; s++) begin
        cur = cur + 4'd1;
        drive(jc[cur], 1'b1);
      end
      expect_out($sformatf("sat_lock%0d", k), cur, 1'b1, 1'b0, 1'b0, 1'b1, exp_err);
      drive(jc[cur], 1'b1);
      exp_err = sat_inc(exp_err);
      expect_out($sformatf("sat_err%0d", k), cur, 1'b1, 1'b0, 1'b1, 1'b0, exp_err);
    end
    chk("sat_final", 32'(err_cnt), 32'hF);

    // Asynchronous reset mid-lock
    for (int s = 0; s < 4; s++) begin
      cur = cur + 4'd1;
      drive(jc[cur], 1'b1);
    end
    expect_out("prereset", cur, 1'b1, 1'b0, 1'b0, 1'b1, exp_err);
    #2 rst = 1'b0;
    #1;
    expect_out("async_reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    @(posedge clk);
    #1;
    expect_out("reset_hold", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    #2 rst = 1'b1;
    for (int s = 0; s < 5; s++) begin
      cur = cur + 4'd1;
      drive(jc[cur], 1'b1);
      expect_out($sformatf("postreset%0d", s), cur, 1'b1, 1'b0, 1'b0, (s == 4), 4'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
